// File: rtl/ripple_carry_adder.sv
// Purpose : WIDTH-bit ripple-carry adder (explicit full-adder chain) with carry-out and signed-overflow flags.
// Latency : 1 cycle; the result is registered on the rising edge that samples in_valid=1.
// Backpressure: none; out_valid is a one-cycle pulse per accepted input, and results hold while idle.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             carry_out,
    output logic             overflow
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic             ovf_comb;

    assign carry[0] = c_in;

    // The carry path is one full adder per bit, chained explicitly so that the
    // ripple structure is what gets built, not an inferred adder.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic prop;
        assign prop         = a[i] ^ b[i];
        assign sum_comb[i]  = prop ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & prop);
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    // For WIDTH=1 the carry into the MSB is c_in itself (carry[0]).
    assign ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];

    logic [WIDTH-1:0] s_d,         s_q;
    logic             carry_out_d, carry_out_q;
    logic             overflow_d,  overflow_q;
    logic             out_valid_d, out_valid_q;

    // Next-state: load a fresh result on accepted input, otherwise hold the
    // previous result; the select is in_valid alone so X operands on idle
    // cycles cannot leak into the held outputs.
    always_comb begin
        s_d         = s_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s_d         = sum_comb;
            carry_out_d = carry[WIDTH];
            overflow_d  = ovf_comb;
        end
    end

    // Output register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
module tb_ripple_carry_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic [W-1:0] s;
    logic         carry_out;
    logic         overflow;

    int passed = 0;
    int total  = 0;

    // Reference state: what the output register should hold after each edge.
    logic [W-1:0] m_s;
    logic         m_co;
    logic         m_ov;
    logic         m_vld;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .s         (s),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Arithmetic model: unsigned sum for s/carry, signed range test for overflow.
    task automatic model_load(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        int unsigned full;
        int          ssum;
        full  = int'(va) + int'(vb) + int'(vc);
        ssum  = int'($signed(va)) + int'($signed(vb)) + int'(vc);
        m_s   = W'(full % (1 << W));
        m_co  = (full >= (1 << W));
        m_ov  = (ssum > ((1 << (W-1)) - 1)) || (ssum < -(1 << (W-1)));
        m_vld = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".s"},   64'(s),         64'(m_s));
        chk({tag, ".co"},  64'(carry_out), 64'(m_co));
        chk({tag, ".ov"},  64'(overflow),  64'(m_ov));
        chk({tag, ".vld"}, 64'(out_valid), 64'(m_vld));
    endtask

    // Drive one cycle of input, advance past the edge, update model, compare.
    task automatic step(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic vv, input string tag);
        a        = va;
        b        = vb;
        c_in     = vc;
        in_valid = vv;
        @(posedge clk);
        #1;
        if (vv) model_load(va, vb, vc);
        else    m_vld = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [8:0] v;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'd5;
        b        = 4'd6;
        c_in     = 1'b0;
        m_s = '0; m_co = 1'b0; m_ov = 1'b0; m_vld = 1'b0;

        // Reset state before any clock edge.
        #2;
        check_all("rst0");

        // Edge while in reset with in_valid=1: input must be dropped.
        @(posedge clk);
        #1;
        check_all("rst_edge");
        rst_n = 1'b1;

        // Idle cycle after release.
        step(4'd0, 4'd0, 1'b0, 1'b0, "idle");

        // Exhaustive, back-to-back.
        for (int i = 0; i < 512; i++) begin
            v = i[8:0];
            step(v[3:0], v[7:4], v[8], 1'b1, "exh");
        end

        // Directed boundary vectors with literal expectations.
        step(4'b1111, 4'b0001, 1'b0, 1'b1, "d_f1");
        chk("d_f1.s_lit", 64'(s), 64'h0);
        chk("d_f1.co_lit", 64'(carry_out), 64'h1);
        chk("d_f1.ov_lit", 64'(overflow), 64'h0);
        step(4'b0111, 4'b0001, 1'b0, 1'b1, "d_71");
        chk("d_71.s_lit", 64'(s), 64'h8);
        chk("d_71.co_lit", 64'(carry_out), 64'h0);
        chk("d_71.ov_lit", 64'(overflow), 64'h1);
        step(4'b1000, 4'b1000, 1'b0, 1'b1, "d_88");
        chk("d_88.s_lit", 64'(s), 64'h0);
        chk("d_88.co_lit", 64'(carry_out), 64'h1);
        chk("d_88.ov_lit", 64'(overflow), 64'h1);
        step(4'b1111, 4'b1111, 1'b1, 1'b1, "d_ffc");
        chk("d_ffc.s_lit", 64'(s), 64'hF);
        chk("d_ffc.co_lit", 64'(carry_out), 64'h1);
        chk("d_ffc.ov_lit", 64'(overflow), 64'h0);
        step(4'b0000, 4'b0000, 1'b1, 1'b1, "d_00c");
        chk("d_00c.s_lit", 64'(s), 64'h1);
        chk("d_00c.co_lit", 64'(carry_out), 64'h0);

        // Hold: load 3+4, then idle with different operands, then X operands.
        step(4'd3, 4'd4, 1'b0, 1'b1, "hold_ld");
        chk("hold_ld.s_lit", 64'(s), 64'h7);
        for (int k = 0; k < 3; k++) begin
            step(4'd9, 4'd9, 1'b0, 1'b0, "hold");
            chk("hold.s_lit", 64'(s), 64'h7);
            chk("hold.vld_lit", 64'(out_valid), 64'h0);
        end
        step(4'bxxxx, 4'bxxxx, 1'bx, 1'b0, "hold_x");
        chk("hold_x.s_lit", 64'(s), 64'h7);

        // Asynchronous reset between edges.
        step(4'd3, 4'd4, 1'b0, 1'b1, "ar_ld");
        #2;
        rst_n = 1'b0;
        #1;
        m_s = '0; m_co = 1'b0; m_ov = 1'b0; m_vld = 1'b0;
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        step(4'd2, 4'd3, 1'b0, 1'b1, "post_rst");
        chk("post_rst.s_lit", 64'(s), 64'h5);

        // Randomized mix of valid and idle cycles against the model.
        for (int r = 0; r < 400; r++) begin
            step(W'($urandom), W'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
